// File: rtl/riscv_wb_pkg.sv
// Shared writeback-stage types and constants for the RV32I core.
package riscv_wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select with reserved-code write suppression.
// Purely combinational so the hazard unit can reuse it.
module wb_result_mux
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  result_src_e           src,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  wr_en
);

  always_comb begin
    result = alu_result;
    wr_en  = wr_en_in;
    case (src)
      RES_ALU:  result = alu_result;
      RES_MEM:  result = mem_data;
      RES_PC4:  result = pc_plus4;
      RES_RSVD: begin
        result = alu_result;
        wr_en  = 1'b0;
      end
      default:  result = alu_result;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback select with forwarding-hit flags.
// Optional retired-instruction counter enabled by RETIRE_COUNT_EN.
module mem_wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ValidM,
  input  logic                      RegWriteM,
  input  logic [1:0]                ResultSrcM,
  input  logic [DATA_WIDTH-1:0]     ALUResultMW,
  input  logic [DATA_WIDTH-1:0]     ReadPartDataM,
  input  logic [DATA_WIDTH-1:0]     PCPlus4M,
  input  logic [31:0]               RdM,
  input  logic                      StallW,
  input  logic                      FlushW,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [DATA_WIDTH-1:0]     ResultW,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic                      RegWriteW,
  output logic                      ValidW,
  output logic                      FwdHitAW,
  output logic                      FwdHitBW
`ifdef RETIRE_COUNT_EN
  , output logic [CNT_WIDTH-1:0]    RetireCountW
`endif
);

  logic                      valid_q, valid_d;
  logic                      regwrite_q, regwrite_d;
  result_src_e               src_q, src_d;
  logic [DATA_WIDTH-1:0]     alu_q, alu_d;
  logic [DATA_WIDTH-1:0]     mem_q, mem_d;
  logic [DATA_WIDTH-1:0]     pc4_q, pc4_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      wr_qual;

  // Upper destination bits are architecturally meaningless here.
  logic unused_rd_hi;
  assign unused_rd_hi = ^RdM[31:REG_ADDR_WIDTH];

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    alu_d      = alu_q;
    mem_d      = mem_q;
    pc4_d      = pc4_q;
    rd_d       = rd_q;
    if (FlushW) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!StallW) begin
      valid_d    = ValidM;
      regwrite_d = RegWriteM;
      src_d      = result_src_e'(ResultSrcM);
      alu_d      = ALUResultMW;
      mem_d      = ReadPartDataM;
      pc4_d      = PCPlus4M;
      rd_d       = RdM[REG_ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= RES_ALU;
      alu_q      <= '0;
      mem_q      <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      alu_q      <= alu_d;
      mem_q      <= mem_d;
      pc4_q      <= pc4_d;
      rd_q       <= rd_d;
    end
  end

  assign wr_qual = valid_q & regwrite_q & (rd_q != REG_ADDR_WIDTH'(REG_ZERO));

  wb_result_mux #(.DATA_WIDTH(DATA_WIDTH)) u_result_mux (
    .src        (src_q),
    .wr_en_in   (wr_qual),
    .alu_result (alu_q),
    .mem_data   (mem_q),
    .pc_plus4   (pc4_q),
    .result     (ResultW),
    .wr_en      (RegWriteW)
  );

  assign RdW      = rd_q;
  assign ValidW   = valid_q;
  assign FwdHitAW = RegWriteW & (rd_q == Rs1E);
  assign FwdHitBW = RegWriteW & (rd_q == Rs2E);

`ifdef RETIRE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A flushed stage still retires the instruction it held going out.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !StallW) cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign RetireCountW = cnt_q;
`else
  localparam int unused_cnt_w = CNT_WIDTH;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 5-stage RV32I core.
- Captures the memory-stage outputs: load data after part-word extraction, ALU result, PC+4, destination register and writeback controls.
- Selects the writeback result and drives the register-file write port.
- Exposes forwarding-hit flags for the execute stage.
- Supports stall (hold) and flush (bubble).

Parameters:
- DATA_WIDTH, 32, width of data/result paths
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 64, width of retire counter (used only with the optional feature)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ValidM  in  1  memory stage holds a real instruction
- RegWriteM  in  1  instruction writes the register file
- ResultSrcM  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
- ALUResultMW  in  DATA_WIDTH  ALU result forwarded through MEM
- ReadPartDataM  in  DATA_WIDTH  extended load data
- PCPlus4M  in  DATA_WIDTH  PC+4 of the instruction
- RdM  in  32  destination register field; only bits [REG_ADDR_WIDTH-1:0] are used
- StallW  in  1  hold stage contents
- FlushW  in  1  replace stage contents with a bubble
- Rs1E, Rs2E  in  REG_ADDR_WIDTH  execute-stage source registers
- ResultW  out  DATA_WIDTH  selected writeback data
- RdW  out  REG_ADDR_WIDTH  register-file write address
- RegWriteW  out  1  register-file write enable
- ValidW  out  1  stage holds a real instruction
- FwdHitAW, FwdHitBW  out  1  writeback result matches Rs1E / Rs2E
- RetireCountW  out  CNT_WIDTH  retired instruction count (present only with RETIRE_COUNT_EN)

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high; it is sampled only at the rising edge of clk.
  - Reset values: ValidW=0, all internal registers 0, RegWriteW=0, ResultW=0, RdW=0, FwdHitAW=FwdHitBW=0, RetireCountW=0.
- Register update priority each edge: rst > FlushW > StallW > load.
  - Flush: valid=0, regwrite=0. Data registers may hold any value; outputs are gated.
  - Stall: every register keeps its value. StallW together with FlushW means flush wins.
  - Load: capture ValidM, RegWriteM, ResultSrcM, ALUResultMW, ReadPartDataM, PCPlus4M and RdM[4:0].
- Latency: 1 cycle from the M inputs to the W outputs. No combinational path from the M inputs to any output.
- ResultW is a combinational mux over the registered values:
  - 00 selects ALU result; 01 selects load data; 10 selects PC+4.
  - 11 selects ALU result and suppresses the write (RegWriteW=0).
- RegWriteW = valid_q & regwrite_q & (rd_q != 0) & (src_q != 11). Writes to x0 are never issued.
- RdW = rd_q. It is driven even when RegWriteW=0; consumers qualify it with RegWriteW.
- FwdHitAW = RegWriteW & (RdW == Rs1E). FwdHitBW is the same with Rs2E. Both are combinational from registered state and the Rs inputs.
- While StallW is held, the outputs are stable and RegWriteW stays asserted if it was. The register file is idempotent, so repeated writes are harmless.
- Reset asserted mid-stall or mid-flush: reset wins that same edge.
- Bubble: ValidM=0 with RegWriteM=1 is captured as valid=0, so no write occurs.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- With the macro defined:
  - The RetireCountW port and a CNT_WIDTH counter exist.
  - Counter increments by 1 on every edge where the stage currently holds a valid instruction (valid_q=1) and is not stalled (StallW=0). FlushW does not block the increment of the outgoing instruction.
  - Counter wraps modulo 2^CNT_WIDTH and resets to 0.
- Without the macro: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package riscv_wb_pkg contains:
  - result_src_e enum: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSVD=2'b11.
  - Constants XLEN=32, REG_ADDR_W=5, REG_ZERO=5'd0.
- One sub-module: wb_result_mux, the purely combinational 4:1 select plus reserved-code write suppression, reusable by the hazard unit.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs at random values -> ValidW=0, RegWriteW=0, ResultW=0, RetireCountW=0.
- Load writeback: ValidM=1, RegWriteM=1, ResultSrcM=01, ReadPartDataM=0xFFFF_FF80, RdM=7 -> next cycle ResultW=0xFFFF_FF80, RdW=7, RegWriteW=1; Rs1E=7 gives FwdHitAW=1.
- x0 and reserved select:
  - RdM=0, ALUResultMW=0x1234 -> RegWriteW=0.
  - ResultSrcM=11, RdM=3 -> RegWriteW=0, ResultW=ALU value.
- Stall: capture JAL with ResultSrcM=10, PCPlus4M=0x0000_0104, RdM=1; hold StallW for 3 cycles while changing the inputs -> ResultW stays 0x104 and RdW stays 1; RetireCountW increments only after release.
- Flush precedence: StallW=1 and FlushW=1 together with a valid ALU write pending -> next cycle ValidW=0, RegWriteW=0.
- Retire count (macro on): 10 valid instructions, 2 bubbles, 1 stall cycle -> RetireCountW=10. Preload the counter near 2^CNT_WIDTH-1 to check wrap to 0.
